// File: rtl/uart_pkg.sv
// Shared UART definitions: widths, receive-FIFO entry layout and frame-size encoding.
package uart_pkg;

    localparam int unsigned UART_BYTE_W   = 8;
    localparam int unsigned RX_ENTRY_W    = 10;
    localparam int unsigned ERR_FRAME_BIT = 9;
    localparam int unsigned ERR_PRTY_BIT  = 8;

    localparam logic DBITS_7 = 1'b0;
    localparam logic DBITS_8 = 1'b1;

    typedef struct packed {
        logic                   err_frame;
        logic                   err_prty;
        logic [UART_BYTE_W-1:0] data;
    } rx_entry_t;

    // 7-bit frames never carry a meaningful bit 7, so it is stored as 0.
    function automatic rx_entry_t pack_rx_entry(
        input logic [UART_BYTE_W-1:0] data,
        input logic                   err_prty,
        input logic                   err_frame,
        input logic                   data_bit_sel
    );
        rx_entry_t e;
        e.err_frame = err_frame;
        e.err_prty  = err_prty;
        e.data      = data;
        if (data_bit_sel == DBITS_7) begin
            e.data[UART_BYTE_W-1] = 1'b0;
        end
        return e;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read. Contents are not reset.
module fifo_mem_dp #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 10,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver with sticky overflow.
// Define RX_FIFO_DROP_ERR_EN to discard bytes flagged with parity/frame errors and count them.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_BYTE_W-1:0] rx_data,
    input  logic                   rx_valid,
    input  logic                   rx_err_prty,
    input  logic                   rx_err_frame,
    input  logic                   data_bit_sel,
    input  logic                   rd_en,
    input  logic                   ovf_clr,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic                   rd_err_prty,
    output logic                   rd_err_frame,
    output logic                   empty,
    output logic                   full,
    output logic [AW:0]            count,
    output logic                   overflow
`ifdef RX_FIFO_DROP_ERR_EN
    ,
    output logic [3:0]             err_drop_cnt
`endif
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d, full_q, full_d, overflow_q, overflow_d;
    logic          accept, push, pop, ovf_evt;
    rx_entry_t     wr_entry, head;
    logic [RX_ENTRY_W-1:0] head_raw;

    fifo_mem_dp #(
        .DEPTH (DEPTH),
        .WIDTH (RX_ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head_raw)
    );

`ifdef RX_FIFO_DROP_ERR_EN
    logic       err_byte;
    logic [3:0] err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        wr_entry = pack_rx_entry(rx_data, rx_err_prty, rx_err_frame, data_bit_sel);
        pop      = rd_en && !empty_q;
`ifdef RX_FIFO_DROP_ERR_EN
        err_byte = rx_valid && (rx_err_prty || rx_err_frame);
        accept   = rx_valid && !err_byte;
        err_cnt_d = err_cnt_q;
        if (err_byte && (err_cnt_q != 4'hF)) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
`else
        accept   = rx_valid;
`endif
        // A pop frees a slot in the same cycle, so a full FIFO can still accept.
        push     = accept && (!full_q || pop);
        ovf_evt  = accept && full_q && !rd_en;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        empty_d  = (count_d == '0);
        full_d   = (count_d == (AW+1)'(DEPTH));

        overflow_d = overflow_q;
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef RX_FIFO_DROP_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        err_drop_cnt = err_cnt_q;
    end
`endif

    always_comb begin
        head         = head_raw;
        rd_data      = empty_q ? '0   : head.data;
        rd_err_prty  = empty_q ? 1'b0 : head_raw[ERR_PRTY_BIT];
        rd_err_frame = empty_q ? 1'b0 : head_raw[ERR_FRAME_BIT];
        empty        = empty_q;
        full         = full_q;
        count        = count_q;
        overflow     = overflow_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0, rx_err_prty = 1'b0, rx_err_frame = 1'b0;
    logic       data_bit_sel = 1'b1, rd_en = 1'b0, ovf_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_err_prty, rd_err_frame, empty, full, overflow;
    logic [4:0] count;
`ifdef RX_FIFO_DROP_ERR_EN
    logic [3:0] err_drop_cnt;
`endif

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_err_prty  (rx_err_prty),
        .rx_err_frame (rx_err_frame),
        .data_bit_sel (data_bit_sel),
        .rd_en        (rd_en),
        .ovf_clr      (ovf_clr),
        .rd_data      (rd_data),
        .rd_err_prty  (rd_err_prty),
        .rd_err_frame (rd_err_frame),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow)
`ifdef RX_FIFO_DROP_ERR_EN
        ,
        .err_drop_cnt (err_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];
    int         mdl_cnt  = 0;
    bit         mdl_ovf  = 1'b0;
    int         mdl_drop = 0;
    logic [9:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT pops an entry, it must be the oldest one the model accepted.
    always @(negedge clk) begin
        if (!rst && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_entry: got 0x%0h, expected no entry", {rd_err_frame, rd_err_prty, rd_data});
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_entry", 32'({rd_err_frame, rd_err_prty, rd_data}), 32'(mon_e));
            end
        end
    end

    task automatic check_status();
        logic [9:0] hd;
        hd = (mdl_cnt > 0 && exp_q.size() > 0) ? exp_q[0] : 10'h0;
        chk("count", 32'(count), 32'(mdl_cnt));
        chk("empty", 32'(empty), 32'(mdl_cnt == 0));
        chk("full", 32'(full), 32'(mdl_cnt == DEPTH));
        chk("overflow", 32'(overflow), 32'(mdl_ovf));
        chk("head", 32'({rd_err_frame, rd_err_prty, rd_data}), 32'(hd));
`ifdef RX_FIFO_DROP_ERR_EN
        chk("err_drop_cnt", 32'(err_drop_cnt), 32'(mdl_drop));
`endif
    endtask

    // Drive one cycle of stimulus, advance the model, then check status after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic pr, input logic fr,
                        input logic dbs, input logic rd, input logic clr);
        bit do_pop, stored, do_push;
        logic [7:0] sd;
        rx_valid = v; rx_data = d; rx_err_prty = pr; rx_err_frame = fr;
        data_bit_sel = dbs; rd_en = rd; ovf_clr = clr;
        do_pop = rd && (mdl_cnt > 0);
        stored = v;
`ifdef RX_FIFO_DROP_ERR_EN
        if (v && (pr || fr)) begin
            stored = 1'b0;
            if (mdl_drop < 15) mdl_drop++;
        end
`endif
        do_push = stored && (mdl_cnt < DEPTH || do_pop);
        sd = dbs ? d : (d & 8'h7F);
        if (do_push) exp_q.push_back({fr, pr, sd});
        mdl_cnt = mdl_cnt + int'(do_push) - int'(do_pop);
        if (stored && !do_push) mdl_ovf = 1'b1;
        else if (clr) mdl_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic idle(input logic rd);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, rd, 1'b0);
    endtask

    initial begin
        bit phase;
        repeat (2) @(posedge clk);
        #1;
        check_status();
        rst = 1'b0;

        // Single byte in, then out; pop on empty must be harmless.
        idle(1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        // 7-bit frame masks bit 7; error flags travel with the byte.
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);

        // Fill, overflow with 0x55, drain, clear the sticky flag.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Push and pop together while full, then while empty.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);

        // Random traffic, alternating fill-biased and drain-biased phases to wrap pointers.
        for (int i = 0; i < 320; i++) begin
            phase = ((i / 40) % 2) == 0;
            step($urandom_range(0, 99) < (phase ? 75 : 30),
                 8'($urandom),
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 15,
                 1'($urandom),
                 $urandom_range(0, 99) < (phase ? 30 : 75),
                 $urandom_range(0, 99) < 10);
        end

        // Reset mid-stream with a push pending: everything is discarded at once.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rx_valid = 1'b1; rx_data = 8'hC3; rd_en = 1'b0; ovf_clr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        exp_q.delete();
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        mdl_drop = 0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check_status();
        rst = 1'b0;
        idle(1'b0);

`ifdef RX_FIFO_DROP_ERR_EN
        step(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("drop_cnt_one", 32'(err_drop_cnt), 32'd1);
        chk("drop_count_one", 32'(count), 32'd1);
        idle(1'b1);
`endif

        step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver.
- Captures each byte the receiver completes, together with its parity/frame error flags, into a first-word-fall-through FIFO.
- The host or parallel consumer drains it with a read strobe, so bytes are not lost when the consumer is slower than the line.
- Reports occupancy, full/empty and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  system clock (same clock as the receiver).
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte from the receiver.
- rx_valid  input  1  single-cycle strobe: rx_data and error flags valid this cycle.
- rx_err_prty  input  1  parity error for this byte.
- rx_err_frame  input  1  framing error for this byte.
- data_bit_sel  input  1  1 = 8-bit frames, 0 = 7-bit frames.
- rd_en  input  1  pop the head entry.
- ovf_clr  input  1  clear the sticky overflow flag.
- rd_data  output  8  head byte (FWFT).
- rd_err_prty  output  1  parity flag of the head entry.
- rd_err_frame  output  1  frame flag of the head entry.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0.
  - Storage array is not reset.
  - rd_data, rd_err_prty and rd_err_frame read 0 while empty.
- Entry format: 10 bits = {err_frame, err_prty, byte}.
  - When data_bit_sel=0, byte bit 7 is stored as 0.
  - data_bit_sel is sampled on the push cycle.
- Push: rx_valid=1 and (not full, or pop in the same cycle).
  - Write entry at wr_ptr; wr_ptr += 1, wrapping modulo DEPTH.
- Pop: rd_en=1 and not empty.
  - rd_ptr += 1, wrapping modulo DEPTH.
  - rd_en while empty is ignored: no pointer move, no flag.
- Count: count_next = count + push - pop. empty = (count==0), full = (count==DEPTH), both registered consistently with count.
- Latency: a byte pushed in cycle N appears on rd_data with empty=0 in cycle N+1.
  - rd_data is combinational from storage at rd_ptr, gated to 0 when empty.
- Simultaneous push and pop:
  - When full: both occur, count stays DEPTH, no overflow.
  - When empty: pop ignored, push occurs, count -> 1.
  - Otherwise: both occur, count unchanged.
- Overflow: rx_valid=1, full=1 and rd_en=0.
  - Byte is dropped; overflow set to 1 next cycle.
  - overflow holds until ovf_clr=1.
  - If a new overflow event and ovf_clr=1 occur in the same cycle, set wins.
- Reset asserted mid-operation discards all contents immediately; a pending push in that cycle is lost.

Optional Feature:
- Macro RX_FIFO_DROP_ERR_EN.
- Defined: bytes with rx_err_prty=1 or rx_err_frame=1 are not stored.
  - A 4-bit saturating counter output err_drop_cnt[3:0] (reset 0, saturates at 15) increments per dropped byte.
  - A dropped error byte never sets overflow, even if the FIFO is full.
- Not defined: every valid byte is stored with its flags; the err_drop_cnt port does not exist.

Decomposition:
- Shared package uart_pkg holds:
  - UART_BYTE_W = 8 and RX_ENTRY_W = 10.
  - Bit indices of the entry fields (ERR_FRAME_BIT = 9, ERR_PRTY_BIT = 8).
  - The data_bit_sel encoding constants DBITS_7 = 0 and DBITS_8 = 1.
- One natural sub-module, fifo_mem_dp: DEPTH x RX_ENTRY_W storage with synchronous write and asynchronous read.
  - Pointers, count, flags and the overflow logic stay in uart_rx_fifo.

Test Plan:
- Reset then push 0xA5 (no errors, data_bit_sel=1) -> next cycle empty=0, count=1, rd_data=0xA5; rd_en one cycle -> empty=1, rd_data=0x00.
- data_bit_sel=0, push 0xFF with rx_err_prty=1 -> rd_data=0x7F, rd_err_prty=1, rd_err_frame=0.
- Push 16 bytes 0x00..0x0F (DEPTH=16) -> full=1, count=16; push 0x55 -> overflow=1, count=16, drained sequence 0x00..0x0F (0x55 absent); ovf_clr -> overflow=0.
- Fill to full, then push 0x99 with rd_en=1 in the same cycle -> overflow stays 0, count=16, last drained byte 0x99; on empty, push+rd_en together -> count=1.
- Interleave 40 pushes/pops to wrap pointers twice -> output order equals input order, count never exceeds 16; assert rst mid-stream -> count=0, empty=1 within the same cycle.
- With RX_FIFO_DROP_ERR_EN defined: push 0x11 (frame error), then 0x22 (clean) -> only 0x22 stored, err_drop_cnt=1.
